serial_addsub4: RTL and testbench
=================================

Name: serial_addsub4

Overview:
Bit-serial WIDTH-bit adder/subtractor sequencer for the add/sub datapath.
- Latches two operands and a mode bit on a start handshake.
- Drives the B-path true/complement select (mode) and processes one bit per clock, LSB first, through a single full-adder slice with a carry flip-flop.
- Registers the result with carry and signed-overflow flags, and signals completion with a one-cycle done pulse.
- Sits between the operand source (register file or testbench) and the result consumer, replacing a ripple chain with a sequential one-slice path.

Parameters:
WIDTH, 4, operand and result width in bits (WIDTH >= 2).

Ports:
Clk  input  1  rising-edge clock; the only clock.
Rst  input  1  synchronous, active-high reset.
Start  input  1  request; sampled only when not busy.
Mode  input  1  0 = A+B, 1 = A-B; latched with Start.
A  input  WIDTH  operand A, two's complement or unsigned; latched with Start.
B  input  WIDTH  operand B; latched with Start.
Busy  output  1  high while an operation is in progress.
Done  output  1  one-cycle pulse: result registers just updated.
Sum  output  WIDTH  registered result; held between operations.
Cout  output  1  carry out of MSB (subtract: 1 = no borrow).
Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
Reset:
- Rst high at a rising edge forces state IDLE, bit counter 0, carry FF 0, and operand/shift registers 0.
- Outputs are Busy=0, Done=0, Sum=0, Cout=0, Ovf=0.
- Reset takes priority over all other inputs.
- Reset mid-operation aborts the operation. No Done is issued and the previous result is lost (cleared to 0).

States:
- IDLE: Busy=0.
  - Start=1 at an edge: latch A into shift register SA, B into SB, Mode into mode register.
  - Load carry FF with Mode (the +1 for two's complement).
  - Clear counter; go to RUN.
  - Start=0: stay in IDLE.
- RUN: Busy=1. Each edge does the following:
  - b_eff = SB[0] XOR mode (the select: mode=1 picks the inverted B bit).
  - s = SA[0] XOR b_eff XOR carry.
  - carry <= majority(SA[0], b_eff, carry).
  - SA and SB shift right by 1.
  - s shifts into the MSB of result shift register SR.
  - Counter increments.
  - On the edge processing bit WIDTH-1, additionally:
    - capture the carry-in of that bit for Ovf;
    - Sum <= final SR contents including that bit, Cout <= new carry, Ovf <= (carry-in of MSB) XOR (new carry);
    - go to DONE.
- DONE: Busy=0, Done=1 for exactly this one cycle.
  - Start=1 at the next edge is accepted exactly as from IDLE (back-to-back operation); otherwise go to IDLE.

Timing:
- If Start is sampled at edge k, RUN spans edges k+1..k+WIDTH.
- Done is high during the cycle after edge k+WIDTH.
- Latency is WIDTH+1 cycles from the Start edge to the Done cycle. Throughput is one operation per WIDTH+1 cycles.

Output and handshake rules:
- Sum, Cout and Ovf change only on the completing edge. They are stable throughout RUN and retain the previous result.
- Start while in RUN is ignored, with no queuing.
- A, B and Mode are don't-care outside the Start sampling edge.

Arithmetic:
- All results are modulo 2^WIDTH.
- Ovf uses two's-complement interpretation. Cout uses unsigned interpretation.

Test Plan:
1. Rst then Start, Mode=0, A=0011, B=0101: Busy high 4 cycles, then Done=1 for 1 cycle, Sum=1000, Cout=0, Ovf=1.
2. Mode=1, A=0111, B=0010 -> Sum=0101, Cout=1, Ovf=0. Then Mode=1, A=0010, B=0111 -> Sum=1011, Cout=0, Ovf=0.
3. Mode=1, A=1000, B=0001 -> Sum=0111, Cout=1, Ovf=1. Mode=0, A=1111, B=0001 -> Sum=0000, Cout=1, Ovf=0.
4. Start pulsed again with different operands during the 2nd RUN cycle -> ignored; result equals the first operation, and only one Done pulse occurs.
5. Start asserted in the Done cycle with A=0001, B=0001, Mode=0 -> accepted immediately; the next Done arrives 5 cycles later with Sum=0010. The previous Sum is held during RUN.
6. Rst asserted in the 3rd RUN cycle -> the next cycle shows Busy=0, Sum=0, Cout=0, Ovf=0, and no Done. A fresh Start afterwards completes normally.

Source files
------------

// File: rtl/serial_addsub4_if.sv
// Operand/result bundle for the bit-serial add/sub sequencer.
// Master supplies operands and start; slave returns status and result.
interface serial_addsub4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub4.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice, LSB first.
// Result, carry and signed overflow register on the final bit's edge.
module serial_addsub4 #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_addsub4_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    logic             carry;

    logic             b_eff;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sr_next;
    logic             last;

    // Single slice: B true/complement select, full adder, result shift-in
    always_comb begin
        b_eff   = sb[0] ^ mode_q;
        s_bit   = sa[0] ^ b_eff ^ carry;
        c_next  = (sa[0] & b_eff) | (sa[0] & carry) | (b_eff & carry);
        sr_next = {s_bit, sr};
        last    = (cnt == CW'(WIDTH - 1));
    end

    // Sequencer: accept start, shift one bit per clock, publish result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            cnt      <= '0;
            mode_q   <= 1'b0;
            carry    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sa       <= bus.a;
                        sb       <= bus.b;
                        mode_q   <= bus.mode;
                        carry    <= bus.mode;
                        sr       <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    carry <= c_next;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sr    <= sr_next[WIDTH-1:1];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        bus.sum  <= sr_next;
                        bus.cout <= c_next;
                        bus.ovf  <= carry ^ c_next;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub4.sv
// Self-checking bench for serial_addsub4: directed table, corner
// sequences and random operations against an arithmetic model.
module tb_serial_addsub4;
    localparam int W = 4;

    logic clk;
    logic rst;

    serial_addsub4_if #(.WIDTH(W)) bus ();

    serial_addsub4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Plain-arithmetic reference: unsigned carry, signed range overflow
    task automatic model(input logic m, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] s,
                         output logic c, output logic o);
        int ua, ub, xa, xb, r, sr;
        ua = int'(a);
        ub = int'(b);
        xa = $signed(a);
        xb = $signed(b);
        if (!m) begin
            r  = ua + ub;
            c  = (r >= 2 ** W);
            sr = xa + xb;
        end else begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = xa - xb;
        end
        s = r[W-1:0];
        o = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic m, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.mode  = 1'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Walk the RUN cycles; optionally pulse start at RUN cycle pulse_at
    task automatic wait_done(input logic [W-1:0] hold, input int pulse_at);
        int n;
        n = 0;
        while (!bus.done && n < 3 * W) begin
            chk("busy_run", int'(bus.busy), 1);
            chk("sum_hold", int'(bus.sum), int'(hold));
            if (n == pulse_at) begin
                bus.start = 1'b1;
                bus.mode  = ~bus.mode;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            step();
            n++;
        end
        bus.start = 1'b0;
        chk("latency", n, W);
        chk("done_seen", int'(bus.done), 1);
        chk("busy_done", int'(bus.busy), 0);
    endtask

    task automatic do_op(input string name, input logic m,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int pulse_at);
        logic [W-1:0] hold, es;
        logic         ec, eo;
        model(m, a, b, es, ec, eo);
        hold = bus.sum;
        start_op(m, a, b);
        wait_done(hold, pulse_at);
        chk({name, "_sum"}, int'(bus.sum), int'(es));
        chk({name, "_cout"}, int'(bus.cout), int'(ec));
        chk({name, "_ovf"}, int'(bus.ovf), int'(eo));
    endtask

    task automatic idle_check();
        step();
        chk("done_pulse", int'(bus.done), 0);
        chk("busy_idle", int'(bus.busy), 0);
    endtask

    initial begin
        logic [W-1:0] hold, es;
        logic         ec, eo;

        tbl[0] = '{1'b0, 4'b0011, 4'b0101, 4'b1000, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 4'b0111, 4'b0010, 4'b0101, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 4'b0010, 4'b0111, 4'b1011, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sum", int'(bus.sum), 0);
        chk("rst_cout", int'(bus.cout), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            hold = bus.sum;
            start_op(tbl[i].m, tbl[i].a, tbl[i].b);
            wait_done(hold, -1);
            chk($sformatf("vec%0d_sum", i), int'(bus.sum), int'(tbl[i].s));
            chk($sformatf("vec%0d_cout", i), int'(bus.cout), int'(tbl[i].c));
            chk($sformatf("vec%0d_ovf", i), int'(bus.ovf), int'(tbl[i].o));
            idle_check();
        end

        do_op("ignore", 1'b0, 4'b0001, 4'b0110, 1);
        idle_check();
        chk("ignore_still_idle", int'(bus.busy), 0);

        do_op("b2b_first", 1'b0, 4'b0100, 4'b1001, -1);
        do_op("b2b", 1'b0, 4'b0001, 4'b0001, -1);
        chk("b2b_const", int'(bus.sum), 2);
        idle_check();

        start_op(1'b0, 4'b0101, 4'b0110);
        step();
        step();
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_sum", int'(bus.sum), 0);
        chk("abort_cout", int'(bus.cout), 0);
        chk("abort_ovf", int'(bus.ovf), 0);
        for (int i = 0; i < W + 2; i++) begin
            step();
            chk("abort_no_done", int'(bus.done), 0);
        end
        do_op("post_rst", 1'b0, 4'b0010, 4'b0011, -1);
        idle_check();

        for (int i = 0; i < 40; i++) begin
            logic         m;
            logic [W-1:0] a, b;
            m = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            model(m, a, b, es, ec, eo);
            hold = bus.sum;
            start_op(m, a, b);
            wait_done(hold, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1);
            chk("rand_sum", int'(bus.sum), int'(es));
            chk("rand_cout", int'(bus.cout), int'(ec));
            chk("rand_ovf", int'(bus.ovf), int'(eo));
            idle_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
